// File: rtl/hood_pkg.sv
// Shared definitions for the hood display: mode codes, segment glyphs,
// digit positions and the per-frame input snapshot.
package hood_pkg;

   typedef enum logic [2:0] {
      MODE_STANDBY = 3'd0,
      MODE_1       = 3'd1,
      MODE_2       = 3'd2,
      MODE_3       = 3'd3,
      MODE_CLEAN   = 3'd4
   } mode_e;

   // Segment bit order is {dp,g,f,e,d,c,b,a}; dp is never lit.
   localparam logic [7:0] GLYPH_BLANK = 8'h00;
   localparam logic [7:0] GLYPH_DASH  = 8'h40;
   localparam logic [7:0] GLYPH_C     = 8'h39;
   localparam logic [7:0] GLYPH_E     = 8'h79;

   localparam logic [9:0][7:0] SEG_FONT = {
      8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D,
      8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
   };

   // Any code above 9 decodes to a dark digit.
   localparam logic [3:0] DIGIT_BLANK = 4'hF;

   localparam logic [2:0] DIG_COUNTDOWN = 3'd0;
   localparam logic [2:0] DIG_BLANK_LO  = 3'd1;
   localparam logic [2:0] DIG_CUM_UNITS = 3'd2;
   localparam logic [2:0] DIG_CUM_TENS  = 3'd3;
   localparam logic [2:0] DIG_CUR_UNITS = 3'd4;
   localparam logic [2:0] DIG_CUR_TENS  = 3'd5;
   localparam logic [2:0] DIG_BLANK_HI  = 3'd6;
   localparam logic [2:0] DIG_MODE      = 3'd7;

   typedef struct packed {
      logic       machineOn;
      logic [2:0] mode;
      logic [5:0] curTime;
      logic [5:0] cumTime;
      logic [2:0] countDown;
   } snap_t;

endpackage

// File: rtl/hood_seg_decode.sv
// Combinational decimal-digit to seven-segment decoder; codes 10-15 are dark.
module hood_seg_decode
   import hood_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [7:0] seg_o
);

   always_comb begin
      seg_o = GLYPH_BLANK;
      if (digit_i < 4'd10) begin
         seg_o = SEG_FONT[digit_i];
      end
   end

endmodule

// File: rtl/hood_time_display.sv
// 8-digit multiplexed seven-segment driver for the range-hood status.
// Optional countdown blink is compiled in with HOOD_DISPLAY_BLINK_EN.
module hood_time_display
   import hood_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 100000,
   parameter int unsigned BLINK_DIV = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       machine_state,
   input  logic [2:0] mode_state,
   input  logic [5:0] current_time,
   input  logic [5:0] cumulative_time,
   input  logic [2:0] count_down_time,
   output logic [7:0] seg_en,
   output logic [7:0] seg_out
);

   localparam int unsigned CW = $clog2(SCAN_DIV);

   logic [CW-1:0] scanCnt_q, scanCnt_d;
   logic [2:0]    digitIdx_q, digitIdx_d;
   snap_t         snap_q, snap_d;
   logic [7:0]    segEn_q, segEn_d;
   logic [7:0]    segOut_q, segOut_d;
   logic          scanWrap;
   logic          blinkPhase;
   logic [7:0]    curBcd, cumBcd;
   logic [3:0]    digitVal;
   logic [7:0]    decSeg;
   logic [7:0]    modeGlyph;

   // Binary 0-63 to {tens,units} by subtracting 40, 20, 10 in turn.
   function automatic logic [7:0] toBcd(input logic [5:0] value);
      logic [5:0] rem;
      logic [3:0] tens;
      rem  = value;
      tens = 4'd0;
      if (rem >= 6'd40) begin rem = rem - 6'd40; tens = tens + 4'd4; end
      if (rem >= 6'd20) begin rem = rem - 6'd20; tens = tens + 4'd2; end
      if (rem >= 6'd10) begin rem = rem - 6'd10; tens = tens + 4'd1; end
      return {tens, 4'(rem)};
   endfunction

   // Snapshot is taken only on the 7->0 step so a frame never mixes inputs.
   always_comb begin
      scanWrap   = (scanCnt_q == CW'(SCAN_DIV - 1));
      scanCnt_d  = scanWrap ? '0 : scanCnt_q + CW'(1);
      digitIdx_d = scanWrap ? digitIdx_q + 3'd1 : digitIdx_q;
      snap_d     = snap_q;
      if (scanWrap && (digitIdx_q == 3'd7)) begin
         snap_d = '{machineOn: machine_state, mode: mode_state,
                    curTime: current_time, cumTime: cumulative_time,
                    countDown: count_down_time};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scanCnt_q  <= '0;
         digitIdx_q <= '0;
         snap_q     <= '0;
         segEn_q    <= '0;
         segOut_q   <= '0;
      end else begin
         scanCnt_q  <= scanCnt_d;
         digitIdx_q <= digitIdx_d;
         snap_q     <= snap_d;
         segEn_q    <= segEn_d;
         segOut_q   <= segOut_d;
      end
   end

`ifdef HOOD_DISPLAY_BLINK_EN
   localparam int unsigned BW = (BLINK_DIV < 2) ? 1 : $clog2(BLINK_DIV);

   logic [BW-1:0] blinkCnt_q;
   logic          blinkPhase_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blinkCnt_q   <= '0;
         blinkPhase_q <= 1'b0;
      end else if (blinkCnt_q == BW'(BLINK_DIV - 1)) begin
         blinkCnt_q   <= '0;
         blinkPhase_q <= ~blinkPhase_q;
      end else begin
         blinkCnt_q   <= blinkCnt_q + BW'(1);
      end
   end

   assign blinkPhase = blinkPhase_q;
`else
   // No blink hardware: the phase stays low for every usable BLINK_DIV.
   assign blinkPhase = (BLINK_DIV == 0);
`endif

   assign curBcd = toBcd(snap_q.curTime);
   assign cumBcd = toBcd(snap_q.cumTime);

   always_comb begin
      digitVal = DIGIT_BLANK;
      case (digitIdx_q)
         DIG_CUR_TENS:  digitVal = curBcd[7:4];
         DIG_CUR_UNITS: digitVal = curBcd[3:0];
         DIG_CUM_TENS:  digitVal = cumBcd[7:4];
         DIG_CUM_UNITS: digitVal = cumBcd[3:0];
         DIG_COUNTDOWN: digitVal = {1'b0, snap_q.countDown};
         DIG_MODE, DIG_BLANK_HI, DIG_BLANK_LO: digitVal = DIGIT_BLANK;
         default:       digitVal = DIGIT_BLANK;
      endcase
   end

   hood_seg_decode u_decode (
      .digit_i (digitVal),
      .seg_o   (decSeg)
   );

   always_comb begin
      modeGlyph = GLYPH_E;
      case (snap_q.mode)
         MODE_STANDBY: modeGlyph = GLYPH_DASH;
         MODE_1:       modeGlyph = SEG_FONT[1];
         MODE_2:       modeGlyph = SEG_FONT[2];
         MODE_3:       modeGlyph = SEG_FONT[3];
         MODE_CLEAN:   modeGlyph = GLYPH_C;
         default:      modeGlyph = GLYPH_E;
      endcase
   end

   // Enable and segments are registered together so digits never ghost.
   always_comb begin
      segEn_d  = 8'h00;
      segOut_d = GLYPH_BLANK;
      if (snap_q.machineOn) begin
         segEn_d = 8'd1 << digitIdx_q;
         if (digitIdx_q == DIG_MODE) begin
            segOut_d = modeGlyph;
         end else if ((digitIdx_q == DIG_COUNTDOWN) && blinkPhase &&
                      (snap_q.countDown != 3'd0)) begin
            segOut_d = GLYPH_BLANK;
         end else begin
            segOut_d = decSeg;
         end
      end
   end

   assign seg_en  = segEn_q;
   assign seg_out = segOut_q;

endmodule

// File: doc/hood_time_display.md
# hood_time_display

Display end of the range-hood controller's status interface. Consumes the machine state, mode code and the three time values the controller produces, and drives the board's 8-digit multiplexed seven-segment display. Scans digits time-multiplexed and converts binary times to decimal. Samples inputs once per frame so a frame never mixes old and new values.

## Interface
- SCAN_DIV, 100000: clock cycles each digit stays lit; 1 ms at 100 MHz.
- BLINK_DIV, 25000000: half-period of the countdown blink in clock cycles; used only with blink compiled in.
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- machine_state  input  1  1 = hood on, 0 = off
- mode_state  input  3  0 standby, 1/2/3 speed modes, 4 self-clean, 5–7 invalid
- current_time  input  6  current-session time, binary 0–63
- cumulative_time  input  6  cumulative time, binary 0–63
- count_down_time  input  3  countdown remaining, binary 0–7
- seg_en  output  8  digit enables, one-hot, active-high; bit i = digit i
- seg_out  output  8  segments {dp,g,f,e,d,c,b,a}, active-high

## Operation
- Free-running scan counter counts 0..SCAN_DIV-1. On wrap, digit index idx advances 7→0→1…→7, wrapping to 0.
- Snapshot: all five inputs are registered into a frame snapshot on the cycle idx advances from 7 to 0. All glyphs are decoded from the snapshot only.
- Digit map:
  - d7: mode glyph. 0 '-' (0x40), 1 '1', 2 '2', 3 '3', 4 'C' (0x39), 5–7 'E' (0x79).
  - d6 and d1: blank (0x00).
  - d5/d4: current_time tens/units.
  - d3/d2: cumulative_time tens/units.
  - d0: count_down_time.
- Digit font for 0–9: 3F 06 5B 4F 66 6D 7D 07 7F 6F. Leading zeros are shown: 7 displays as "07".
- BCD conversion: tens = value/10 (0–6), units = value − 10·tens. Uses a compare-subtract chain; no divider.
- Snapshot machine_state = 0: seg_en = 0x00 and seg_out = 0x00 for the whole frame. The scan keeps running.
- Otherwise seg_en = 1<<idx, and seg_out is the glyph for idx. dp is always 0.

## Timing
- Reset: scan counter 0, idx 0, snapshot all 0, seg_en 0x00, seg_out 0x00, blink phase 0.
- seg_en and seg_out are registered. They update one cycle after idx changes, together in the same cycle, so there is no ghosting between digits.
- After reset release, the first snapshot is taken at the first 7→0 transition, 8·SCAN_DIV cycles later. Until then the outputs show snapshot 0, which is machine off, so the display is dark.
- Input changes take effect at the next frame boundary. Worst-case latency is 8·SCAN_DIV+1 cycles.
- Reset asserted mid-frame: all state clears immediately, and outputs go to 0x00 asynchronously.
- SCAN_DIV must be ≥2. Counter width is $clog2(SCAN_DIV).

## Configuration
- HOOD_DISPLAY_BLINK_EN defined:
  - A BLINK_DIV counter toggles a blink phase bit.
  - When snapshot count_down_time ≠ 0 and the phase is 1, d0 shows 0x00 with its seg_en bit still asserted.
  - When count_down_time = 0, d0 shows steadily.
  - The blink counter runs independently of the scan.
- Not defined: no blink counter is instantiated, and d0 always shows steadily.

## Structure
- Shared package hood_pkg: mode encodings (MODE_STANDBY=0, MODE_1..MODE_3, MODE_CLEAN=4), the glyph constants listed above, and the digit-position constants.
- One sub-module, hood_seg_decode: combinational 4-bit digit → 8-bit segment decoder. Inputs 10–15 give 0x00. Instantiated once, on the muxed digit value.
- Mode-glyph selection and BCD conversion stay in the top level of this block.

## Test plan
All scenarios run with SCAN_DIV=4 and BLINK_DIV=16.
- Reset: hold rst_n=0 → seg_en=0x00, seg_out=0x00. Release with machine_state=0 → outputs stay 0x00 for 3 frames.
- Full frame: machine_state=1, mode=2, current=45, cumulative=7, countdown=3. After the first frame boundary, per digit:
  - d7 = 0x5B
  - d5 = 0x66, d4 = 0x6D
  - d3 = 0x3F, d2 = 0x07
  - d0 = 0x4F
  - d6 and d1 = 0x00
  - seg_en steps 0x01→0x02…→0x80 with one-hot, 4-cycle dwell.
- Tear-free update: change current_time from 45 to 63 while idx=5 → the rest of the frame still shows 4/5, and the next frame shows 6/3.
- Mode glyphs: sweep mode 0..7 → d7 = 0x40, 06, 5B, 4F, 39, 79, 79, 79.
- Reset mid-frame: assert rst_n at idx=3 → same-cycle asynchronous outputs 0x00 and idx=0 after release.
- With HOOD_DISPLAY_BLINK_EN:
  - countdown=5 → d0 alternates between 0x6D and 0x00 every 16 cycles of phase.
  - countdown=0 → d0 stays at 0x3F.
